// File: rtl/main_ram_ctrl.sv
// Sequencer and two-port arbiter for an asynchronous SRAM with registered, glitch-free strobes.
// Optional MAIN_RAM_RR_EN selects round-robin arbitration instead of fixed port-0 priority.
module main_ram_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 20,
    parameter int RD_WAIT    = 2,
    parameter int WR_PULSE   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0]      wdata0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0]      wdata1,
    output logic                  ack1,
    output logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic                  _ram_cs,
    output logic                  _ram_oe,
    output logic                  _ram_w,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_din,
    input  logic [WIDTH-1:0]      ram_dout
);

    localparam int MAX_WAIT = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
    localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_WR_LOAD = CNT_W'(WR_PULSE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RWAIT,
        ST_WSTROBE,
        ST_WHOLD,
        ST_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    op_we_reg, op_we_next;
    logic                    grant_reg, grant_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [WIDTH-1:0]        din_reg, din_next;
    logic [WIDTH-1:0]        rdata_reg, rdata_next;
    logic                    cs_reg, cs_next;
    logic                    oe_reg, oe_next;
    logic                    w_reg, w_next;
    logic                    ack0_reg, ack0_next;
    logic                    ack1_reg, ack1_next;
    logic                    busy_reg, busy_next;

    logic any_req;
    logic pick;     // 1 selects port 1

    assign any_req = req0 | req1;

`ifdef MAIN_RAM_RR_EN
    logic last_grant_reg;

    // On a tie the port granted most recently yields.
    always_comb begin
        pick = ~req0;
        if (req0 && req1) begin
            pick = ~last_grant_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
        end else if (state_reg == ST_IDLE && any_req) begin
            last_grant_reg <= pick;
        end
    end
`else
    assign pick = ~req0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_we_next = op_we_reg;
        grant_next = grant_reg;
        addr_next  = addr_reg;
        din_next   = din_reg;
        rdata_next = rdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    grant_next = pick;
                    op_we_next = pick ? we1 : we0;
                    addr_next  = pick ? addr1 : addr0;
                    din_next   = pick ? wdata1 : wdata0;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (op_we_reg) begin
                    cnt_next   = CNT_WR_LOAD;
                    state_next = ST_WSTROBE;
                end else begin
                    cnt_next   = CNT_RD_LOAD;
                    state_next = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (cnt_reg == '0) begin
                    rdata_next = ram_dout;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_WSTROBE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_WHOLD;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_WHOLD: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they leave a flop, never a gate.
        cs_next   = ~((state_next == ST_SETUP) || (state_next == ST_RWAIT) ||
                      (state_next == ST_WSTROBE) || (state_next == ST_WHOLD));
        oe_next   = ~(((state_next == ST_SETUP) || (state_next == ST_RWAIT)) && !op_we_next);
        w_next    = ~(state_next == ST_WSTROBE);
        ack0_next = (state_next == ST_DONE) && !grant_next;
        ack1_next = (state_next == ST_DONE) &&  grant_next;
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_we_reg <= 1'b0;
            grant_reg <= 1'b0;
            addr_reg  <= '0;
            din_reg   <= '0;
            rdata_reg <= '0;
            cs_reg    <= 1'b1;
            oe_reg    <= 1'b1;
            w_reg     <= 1'b1;
            ack0_reg  <= 1'b0;
            ack1_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_we_reg <= op_we_next;
            grant_reg <= grant_next;
            addr_reg  <= addr_next;
            din_reg   <= din_next;
            rdata_reg <= rdata_next;
            cs_reg    <= cs_next;
            oe_reg    <= oe_next;
            w_reg     <= w_next;
            ack0_reg  <= ack0_next;
            ack1_reg  <= ack1_next;
            busy_reg  <= busy_next;
        end
    end

    assign _ram_cs  = cs_reg;
    assign _ram_oe  = oe_reg;
    assign _ram_w   = w_reg;
    assign ram_addr = addr_reg;
    assign ram_din  = din_reg;
    assign rdata    = rdata_reg;
    assign ack0     = ack0_reg;
    assign ack1     = ack1_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_main_ram_ctrl.sv
// Directed bench for main_ram_ctrl: default-timing instance plus a RD_WAIT=1/WR_PULSE=1 instance,
// each backed by a small behavioural SRAM that writes on the falling edge of _w.
module tb_main_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // instance A: default timing, both ports exercised
    logic        req0, we0, req1, we1, ack0, ack1, a_busy, a_cs, a_oe, a_w;
    logic [19:0] addr0, addr1, a_addr;
    logic [7:0]  wdata0, wdata1, a_rdata, a_din, a_dout;

    // instance B: single-cycle strobes, port 1 idle
    logic        b_req0, b_we0, b_ack0, b_req1, b_we1, b_ack1, b_busy, b_cs, b_oe, b_w;
    logic [19:0] b_addr0, b_addr1, b_addr;
    logic [7:0]  b_wdata0, b_wdata1, b_rdata, b_din, b_dout;

    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];

    int n_cmp  = 0;
    int n_fail = 0;

    main_ram_ctrl #(.WIDTH(8), .ADDR_WIDTH(20), .RD_WAIT(2), .WR_PULSE(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(a_rdata), .busy(a_busy),
        ._ram_cs(a_cs), ._ram_oe(a_oe), ._ram_w(a_w),
        .ram_addr(a_addr), .ram_din(a_din), .ram_dout(a_dout)
    );

    main_ram_ctrl #(.WIDTH(8), .ADDR_WIDTH(20), .RD_WAIT(1), .WR_PULSE(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1),
        .rdata(b_rdata), .busy(b_busy),
        ._ram_cs(b_cs), ._ram_oe(b_oe), ._ram_w(b_w),
        .ram_addr(b_addr), .ram_din(b_din), .ram_dout(b_dout)
    );

    always @(negedge a_w) if (!a_cs) mem_a[a_addr[7:0]] <= a_din;
    always @(negedge b_w) if (!b_cs) mem_b[b_addr[7:0]] <= b_din;
    assign a_dout = (!a_cs && !a_oe) ? mem_a[a_addr[7:0]] : 8'h00;
    assign b_dout = (!b_cs && !b_oe) ? mem_b[b_addr[7:0]] : 8'h00;

    // Drive one request and watch it: k counts falling edges after grant edge E0.
    task automatic do_txn(input bit sel, input bit port, input bit we, input logic [19:0] addr,
                          input logic [7:0] wd, output int ack_k, output int cs_n, output int oe_n,
                          output int w_n, output int busy_n, output logic [7:0] rd, output int viol);
        logic [19:0] hold_addr;
        logic [7:0]  hold_din;
        logic        cs_s, oe_s, w_s, ack_s, other_s, busy_s;
        bit          held;
        ack_k = 0; cs_n = 0; oe_n = 0; w_n = 0; busy_n = 0; rd = '0; viol = 0; held = 0;
        hold_addr = '0; hold_din = '0;
        @(negedge clk);
        if (sel) begin
            b_req0 = 1'b1; b_we0 = we; b_addr0 = addr; b_wdata0 = wd;
        end else if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
        end
        for (int k = 1; k <= 30 && ack_k == 0; k++) begin
            @(negedge clk);
            cs_s    = sel ? b_cs : a_cs;
            oe_s    = sel ? b_oe : a_oe;
            w_s     = sel ? b_w  : a_w;
            busy_s  = sel ? b_busy : a_busy;
            ack_s   = sel ? b_ack0 : (port ? ack1 : ack0);
            other_s = sel ? b_ack1 : (port ? ack0 : ack1);
            if (!cs_s) begin
                cs_n++;
                if (!held) begin
                    held = 1; hold_addr = sel ? b_addr : a_addr; hold_din = sel ? b_din : a_din;
                end else if ((sel ? b_addr : a_addr) !== hold_addr || (sel ? b_din : a_din) !== hold_din) begin
                    viol++;
                end
            end
            if (!oe_s) oe_n++;
            if (!w_s) w_n++;
            if (busy_s) busy_n++;
            if (!w_s && !oe_s) viol++;
            if (other_s) viol++;
            if (ack_s) begin
                ack_k = k;
                rd = sel ? b_rdata : a_rdata;
            end
        end
        b_req0 = 1'b0; req0 = (sel || port) ? req0 : 1'b0; req1 = (!sel && port) ? 1'b0 : req1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({a_cs, a_oe, a_w} !== 3'b111) begin n_fail++; $display("FAIL reset_strobes got %b want 111", {a_cs, a_oe, a_w}); end
        n_cmp++; if ({ack0, ack1, a_busy} !== 3'b000) begin n_fail++; $display("FAIL reset_ack_busy got %b want 000", {ack0, ack1, a_busy}); end
        n_cmp++; if (a_rdata !== 8'h00 || a_addr !== 20'h0 || a_din !== 8'h00) begin n_fail++; $display("FAIL reset_data got rdata=%h addr=%h din=%h want 0", a_rdata, a_addr, a_din); end
        n_cmp++; if ({b_cs, b_oe, b_w, b_busy} !== 4'b1110) begin n_fail++; $display("FAIL reset_b got %b want 1110", {b_cs, b_oe, b_w, b_busy}); end
        reset = 1'b0;
        $display("txn reset: strobes=%b busy=%b", {a_cs, a_oe, a_w}, a_busy);
    endtask

    task automatic test_write();
        int ack_k, cs_n, oe_n, w_n, busy_n, viol;
        logic [7:0] rd;
        do_txn(0, 0, 1, 20'h00010, 8'hA5, ack_k, cs_n, oe_n, w_n, busy_n, rd, viol);
        $display("txn write p0 a=00010 d=A5: ack_k=%0d cs=%0d w=%0d", ack_k, cs_n, w_n);
        n_cmp++; if (ack_k !== 5) begin n_fail++; $display("FAIL write_latency got %0d want 5", ack_k); end
        n_cmp++; if (cs_n !== 4) begin n_fail++; $display("FAIL write_cs_width got %0d want 4", cs_n); end
        n_cmp++; if (w_n !== 2) begin n_fail++; $display("FAIL write_w_width got %0d want 2", w_n); end
        n_cmp++; if (oe_n !== 0) begin n_fail++; $display("FAIL write_oe_width got %0d want 0", oe_n); end
        n_cmp++; if (busy_n !== 5) begin n_fail++; $display("FAIL write_busy got %0d want 5", busy_n); end
        n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL write_protocol got %0d want 0", viol); end
        n_cmp++; if (mem_a[8'h10] !== 8'hA5) begin n_fail++; $display("FAIL write_ram got %h want a5", mem_a[8'h10]); end
        n_cmp++; if (a_rdata !== 8'h00) begin n_fail++; $display("FAIL write_rdata_untouched got %h want 00", a_rdata); end
    endtask

    task automatic test_read();
        int ack_k, cs_n, oe_n, w_n, busy_n, viol;
        logic [7:0] rd;
        do_txn(0, 0, 0, 20'h00010, 8'h00, ack_k, cs_n, oe_n, w_n, busy_n, rd, viol);
        $display("txn read p0 a=00010: ack_k=%0d cs=%0d oe=%0d rdata=%h", ack_k, cs_n, oe_n, rd);
        n_cmp++; if (ack_k !== 4) begin n_fail++; $display("FAIL read_latency got %0d want 4", ack_k); end
        n_cmp++; if (cs_n !== 3 || oe_n !== 3) begin n_fail++; $display("FAIL read_strobe_width got cs=%0d oe=%0d want 3/3", cs_n, oe_n); end
        n_cmp++; if (w_n !== 0 || viol !== 0) begin n_fail++; $display("FAIL read_protocol got w=%0d viol=%0d want 0/0", w_n, viol); end
        n_cmp++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL read_data got %h want a5", rd); end
        repeat (3) @(negedge clk);
        n_cmp++; if (a_rdata !== 8'hA5 || a_busy !== 1'b0) begin n_fail++; $display("FAIL read_hold got rdata=%h busy=%b want a5/0", a_rdata, a_busy); end
    endtask

    task automatic test_arbitration();
        int ack_k, cs_n, oe_n, w_n, busy_n, viol, k0, k1, na;
        logic [7:0] rd, rd0, rd1;
        int order [4];
        int exp_order [4];
        logic [7:0] rds [4];
        do_txn(0, 1, 1, 20'h00020, 8'h3C, ack_k, cs_n, oe_n, w_n, busy_n, rd, viol);
        $display("txn write p1 a=00020 d=3C: ack_k=%0d", ack_k);
        n_cmp++; if (ack_k !== 5 || viol !== 0) begin n_fail++; $display("FAIL p1_write got ack_k=%0d viol=%0d want 5/0", ack_k, viol); end
        n_cmp++; if (mem_a[8'h20] !== 8'h3C || a_rdata !== 8'hA5) begin n_fail++; $display("FAIL p1_write_effect got ram=%h rdata=%h want 3c/a5", mem_a[8'h20], a_rdata); end
        // simultaneous reads, each requester drops on its ack
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00020;
        k0 = 0; k1 = 0; rd0 = '0; rd1 = '0;
        for (int k = 1; k <= 40 && (k0 == 0 || k1 == 0); k++) begin
            @(negedge clk);
            if (ack0) begin k0 = k; rd0 = a_rdata; req0 = 1'b0; end
            if (ack1) begin k1 = k; rd1 = a_rdata; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        $display("txn tie: ack0 k=%0d rdata=%h ack1 k=%0d rdata=%h", k0, rd0, k1, rd1);
        n_cmp++; if (k0 !== 4 || rd0 !== 8'hA5) begin n_fail++; $display("FAIL tie_port0 got k=%0d rdata=%h want 4/a5", k0, rd0); end
        n_cmp++; if (k1 !== 9 || rd1 !== 8'h3C) begin n_fail++; $display("FAIL tie_port1 got k=%0d rdata=%h want 9/3c", k1, rd1); end
        // both held for four grants
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; na = 0;
        for (int c = 0; c < 100 && na < 4; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                order[na] = ack1 ? 1 : 0; rds[na] = a_rdata; na++;
                if (na == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
`ifdef MAIN_RAM_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        n_cmp++; if (na !== 4) begin n_fail++; $display("FAIL held_tie_count got %0d want 4", na); end
        for (int i = 0; i < na; i++) begin
            $display("txn held tie %0d: port=%0d rdata=%h", i, order[i], rds[i]);
            n_cmp++;
            if (order[i] !== exp_order[i] || rds[i] !== (exp_order[i] == 1 ? 8'h3C : 8'hA5)) begin
                n_fail++; $display("FAIL held_tie_%0d got port=%0d rdata=%h want port=%0d", i, order[i], rds[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ack_k, cs_n, oe_n, w_n, busy_n, viol, stray;
        logic [7:0] rd;
        bit hit;
        hit = 0; stray = 0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'h00040; wdata0 = 8'h77;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (!a_w) hit = 1;
        end
        n_cmp++; if (!hit) begin n_fail++; $display("FAIL rst_mid_reach_wstrobe got no _w low want low"); end
        reset = 1'b1;
        #1;
        $display("txn reset during wstrobe: strobes=%b busy=%b ack0=%b", {a_cs, a_oe, a_w}, a_busy, ack0);
        n_cmp++; if ({a_cs, a_w} !== 2'b11) begin n_fail++; $display("FAIL rst_mid_strobes got cs=%b w=%b want 1/1", a_cs, a_w); end
        n_cmp++; if (a_busy !== 1'b0 || ack0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy_ack got busy=%b ack0=%b want 0/0", a_busy, ack0); end
        req0 = 1'b0;
        repeat (2) begin @(negedge clk); if (ack0 || ack1) stray++; end
        reset = 1'b0;
        repeat (6) begin @(negedge clk); if (ack0 || ack1 || a_busy) stray++; end
        n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL rst_mid_no_ack got %0d stray cycles want 0", stray); end
        do_txn(0, 0, 1, 20'h00040, 8'h99, ack_k, cs_n, oe_n, w_n, busy_n, rd, viol);
        $display("txn write p0 a=00040 d=99 after reset: ack_k=%0d", ack_k);
        n_cmp++; if (ack_k !== 5 || mem_a[8'h40] !== 8'h99) begin n_fail++; $display("FAIL rst_mid_recover got k=%0d ram=%h want 5/99", ack_k, mem_a[8'h40]); end
    endtask

    task automatic test_back_to_back();
        int n1, k1a, k1b, k0, early;
        logic [7:0] r1a, r1b, r0;
        n1 = 0; k1a = 0; k1b = 0; k0 = 0; early = 0; r1a = '0; r1b = '0; r0 = '0;
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00020;
        for (int k = 1; k <= 60 && k0 == 0; k++) begin
            @(negedge clk);
            if (k1a != 0 && k == k1a + 2) begin req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00010; end
            if (ack1) begin
                n1++;
                if (n1 == 1) begin k1a = k; r1a = a_rdata; end
                else begin k1b = k; r1b = a_rdata; req1 = 1'b0; end
            end
            if (ack0) begin
                k0 = k; r0 = a_rdata; req0 = 1'b0;
                if (n1 < 2) early++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        $display("txn held req1: ack1 k=%0d,%0d rdata=%h,%h then ack0 k=%0d rdata=%h", k1a, k1b, r1a, r1b, k0, r0);
        n_cmp++; if (k1a !== 4 || r1a !== 8'h3C) begin n_fail++; $display("FAIL b2b_first got k=%0d rdata=%h want 4/3c", k1a, r1a); end
        n_cmp++; if (k1b !== 9 || r1b !== 8'h3C) begin n_fail++; $display("FAIL b2b_second got k=%0d rdata=%h want 9/3c", k1b, r1b); end
        n_cmp++; if (k0 !== 14 || r0 !== 8'hA5 || early !== 0) begin n_fail++; $display("FAIL b2b_port0 got k=%0d rdata=%h early=%0d want 14/a5/0", k0, r0, early); end
    endtask

    task automatic test_short_timing();
        int ack_k, cs_n, oe_n, w_n, busy_n, viol;
        logic [7:0] rd;
        do_txn(1, 0, 1, 20'h00030, 8'h5A, ack_k, cs_n, oe_n, w_n, busy_n, rd, viol);
        $display("txn short write a=00030 d=5A: ack_k=%0d cs=%0d w=%0d", ack_k, cs_n, w_n);
        n_cmp++; if (ack_k !== 4 || cs_n !== 3 || w_n !== 1) begin n_fail++; $display("FAIL short_write got k=%0d cs=%0d w=%0d want 4/3/1", ack_k, cs_n, w_n); end
        n_cmp++; if (mem_b[8'h30] !== 8'h5A || viol !== 0) begin n_fail++; $display("FAIL short_write_ram got %h viol=%0d want 5a/0", mem_b[8'h30], viol); end
        do_txn(1, 0, 0, 20'h00030, 8'h00, ack_k, cs_n, oe_n, w_n, busy_n, rd, viol);
        $display("txn short read a=00030: ack_k=%0d cs=%0d oe=%0d rdata=%h", ack_k, cs_n, oe_n, rd);
        n_cmp++; if (ack_k !== 3 || cs_n !== 2 || oe_n !== 2) begin n_fail++; $display("FAIL short_read got k=%0d cs=%0d oe=%0d want 3/2/2", ack_k, cs_n, oe_n); end
        n_cmp++; if (rd !== 8'h5A || viol !== 0) begin n_fail++; $display("FAIL short_read_data got %h viol=%0d want 5a/0", rd, viol); end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
        b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;
        for (int i = 0; i < 256; i++) begin mem_a[i] = 8'h00; mem_b[i] = 8'h00; end
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_reset_mid();
        test_back_to_back();
        test_short_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
